// File: rtl/download_ddr_packer_pkg.sv
// rtl/download_ddr_packer_pkg.sv - shared types and helpers for the download-to-DDR packer
package cave_dl_pkg;

  localparam int LANES      = 4;
  localparam int BEAT_BYTES = 8;
  localparam int DDR_ADDR_W = 32;
  localparam int LINE_W     = DDR_ADDR_W - $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  typedef struct packed {
    logic [63:0]       data;
    logic [7:0]        mask;
    logic [LINE_W-1:0] line;
  } beat_t;

  function automatic logic [7:0] lane_mask(input logic [1:0] lane);
    return 8'b0000_0011 << {lane, 1'b0};
  endfunction

  function automatic logic [63:0] expand_mask(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < BEAT_BYTES; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/download_ddr_packer_if.sv
// rtl/download_ddr_packer_if.sv - ioctl download side and DDR write side of the packer
interface download_ddr_packer_if #(
  parameter int ADDR_WIDTH = 25
);
  logic                  dl_cs;
  logic                  dl_wr;
  logic [ADDR_WIDTH-1:0] dl_addr;
  logic [15:0]           dl_dout;
  logic                  dl_wait;
  logic                  ddr_wr;
  logic [31:0]           ddr_addr;
  logic [63:0]           ddr_din;
  logic [7:0]            ddr_mask;
  logic [7:0]            ddr_burstLength;
  logic                  ddr_waitReq;
  logic                  done;
  logic                  overflow;

  modport slave (
    input  dl_cs, dl_wr, dl_addr, dl_dout, ddr_waitReq,
    output dl_wait, ddr_wr, ddr_addr, ddr_din, ddr_mask, ddr_burstLength, done, overflow
  );

  modport master (
    output dl_cs, dl_wr, dl_addr, dl_dout, ddr_waitReq,
    input  dl_wait, ddr_wr, ddr_addr, ddr_din, ddr_mask, ddr_burstLength, done, overflow
  );
endinterface

// File: rtl/download_ddr_packer_beat_buffer.sv
// rtl/download_ddr_packer_beat_buffer.sv - single-entry Avalon write holder
module dl_beat_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [63:0] data_i,
  input  logic [7:0]  mask_i,
  input  logic [31:0] addr_i,
  input  logic        wait_req_i,
  output logic        valid_o,
  output logic        accept_o,
  output logic [63:0] data_o,
  output logic [7:0]  mask_o,
  output logic [31:0] addr_o
);
  logic        valid_q;
  logic [63:0] data_q;
  logic [7:0]  mask_q;
  logic [31:0] addr_q;

  assign accept_o = valid_q & ~wait_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      mask_q  <= mask_i;
      addr_q  <= addr_i;
    end else if (accept_o) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mask_o  = mask_q;
  assign addr_o  = addr_q;
endmodule

// File: rtl/download_ddr_packer.sv
// rtl/download_ddr_packer.sv - packs 16-bit ioctl words into masked 64-bit DDR beats
module download_ddr_packer
  import cave_dl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 25
) (
  input logic                  clock,
  input logic                  reset_n,
  download_ddr_packer_if.slave bus
);
  state_t state_q, state_d;
  beat_t  fill_q, fill_d, cur, word, load_beat;
  logic   fill_full_q, fill_full_d;
  logic   cs_q, dl_wait_q, dl_wait_d, done_q, done_d, overflow_q, overflow_d;
  logic   load, out_clear, out_valid, out_accept, out_valid_d, complete;
  logic   cs_rise, cs_fall, same_line, fits, accept_word, drop, line_change;
  logic [$clog2(LANES)-1:0] lane;
  logic   unused_addr_bit;

  assign unused_addr_bit = bus.dl_addr[0];
  assign lane            = bus.dl_addr[2:1];
  assign word.data       = 64'(bus.dl_dout) << {lane, 4'b0000};
  assign word.mask       = lane_mask(lane);
  assign word.line       = LINE_W'(bus.dl_addr[ADDR_WIDTH-1:3]);

  assign cs_rise     = bus.dl_cs & ~cs_q;
  assign cs_fall     = ~bus.dl_cs & cs_q;
  assign same_line   = (fill_q.line == word.line);
  // While stalled, a word is still taken if it lands in the open, non-full fill.
  assign fits        = ~fill_full_q & ((fill_q.mask == 8'd0) | same_line);
  assign accept_word = bus.dl_wr & (state_q == ACTIVE) & (~dl_wait_q | fits);
  assign drop        = bus.dl_wr & (state_q == ACTIVE) & ~accept_word;
  assign line_change = accept_word & (fill_q.mask != 8'd0) & ~same_line;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    fill_full_d = fill_full_q;
    cur         = fill_q;
    load        = 1'b0;
    load_beat   = fill_q;
    out_clear   = 1'b0;
    complete    = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d     = ACTIVE;
          fill_d      = '0;
          fill_full_d = 1'b0;
          out_clear   = 1'b1;
        end
      end
      default: begin
        // A held full fill waits a whole cycle of empty out before moving in.
        if (fill_full_q) begin
          if (!out_valid) begin
            load        = 1'b1;
            fill_d      = '0;
            fill_full_d = 1'b0;
          end
        end else begin
          if (accept_word) begin
            if (line_change) begin
              load = 1'b1;
              cur  = word;
            end else if (fill_q.mask == 8'd0) begin
              cur = word;
            end else begin
              cur.data = (fill_q.data & ~expand_mask(word.mask)) | word.data;
              cur.mask = fill_q.mask | word.mask;
            end
            complete = (lane == 2'd3);
          end
          if ((state_q == ACTIVE) && cs_fall && (cur.mask != 8'd0)) complete = 1'b1;
          if (complete && !load && (!out_valid || out_accept)) begin
            load      = 1'b1;
            load_beat = cur;
            fill_d    = '0;
          end else begin
            fill_d      = cur;
            fill_full_d = complete;
          end
        end
      end
    endcase

    out_valid_d = ~out_clear & (load | (out_valid & ~out_accept));

    if ((state_q == ACTIVE) && cs_fall) begin
      if ((fill_d.mask == 8'd0) && !out_valid_d) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = DRAIN;
      end
    end
    if ((state_q == DRAIN) && (fill_q.mask == 8'd0) && !out_valid) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end

    dl_wait_d  = out_valid_d | fill_full_d;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      fill_full_q <= 1'b0;
      cs_q        <= 1'b0;
      dl_wait_q   <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      fill_full_q <= fill_full_d;
      cs_q        <= bus.dl_cs;
      dl_wait_q   <= dl_wait_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  dl_beat_buffer u_out (
    .clk        (clock),
    .rst_n      (reset_n),
    .clear_i    (out_clear),
    .load_i     (load),
    .data_i     (load_beat.data),
    .mask_i     (load_beat.mask),
    .addr_i     (BASE_ADDR + {load_beat.line, 3'b000}),
    .wait_req_i (bus.ddr_waitReq),
    .valid_o    (out_valid),
    .accept_o   (out_accept),
    .data_o     (bus.ddr_din),
    .mask_o     (bus.ddr_mask),
    .addr_o     (bus.ddr_addr)
  );

  assign bus.ddr_wr          = out_valid;
  assign bus.ddr_burstLength = 8'd1;
  assign bus.dl_wait         = dl_wait_q;
  assign bus.done            = done_q;
  assign bus.overflow        = overflow_q;
endmodule

// File: doc/download_ddr_packer.md
Name: download_ddr_packer

Overview:
Sits between hps_io's ioctl download port and the DDR3 arbiter write path.
- Packs 16-bit download words (byte address, little-endian) into 64-bit DDR beats with byte masks.
- Issues single-beat Avalon-style writes, holding them until waitReq clears.
- Throttles the downloader through dl_wait.
- Flushes partial beats on address discontinuity and at end of download.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte offset added to every DDR write address.
- ADDR_WIDTH, 25, width of the download address.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dl_cs  in  1  download active (ioctl_download).
- dl_wr  in  1  one-cycle word-valid strobe.
- dl_addr  in  ADDR_WIDTH  byte address of the word; bit 0 is ignored.
- dl_dout  in  16  download data word.
- dl_wait  out  1  stall request to the downloader.
- ddr_wr  out  1  write request.
- ddr_addr  out  32  byte address, 8-byte aligned.
- ddr_din  out  64  write data.
- ddr_mask  out  8  byte enables.
- ddr_burstLength  out  8  constant 8'd1.
- ddr_waitReq  in  1  arbiter busy.
- done  out  1  one-cycle pulse when a download has fully drained.
- overflow  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, reset_n=0): all outputs 0 except ddr_burstLength=1; both buffers empty; state IDLE. Asserting reset mid-write drops ddr_wr immediately and discards buffered data.
- Lane mapping: lane k = dl_addr[2:1]. Data goes to bits [16k+15:16k]; mask bits 2k and 2k+1 are set. Line = dl_addr[ADDR_WIDTH-1:3].
- Buffers:
  - Fill buffer: data, mask, line.
  - Out buffer: data, mask, addr, valid.
- State machine:
  - IDLE→ACTIVE on dl_cs rising. Buffers are cleared on entry.
  - ACTIVE→DRAIN on dl_cs falling.
  - DRAIN→IDLE once the fill mask is 0 and out is not valid. done pulses in that cycle.
  - DRAIN with the fill mask already 0 on entry goes straight to IDLE.
- Accepting a dl_wr in ACTIVE:
  - Fill mask 0: set the line and write the lane.
  - Same line: write the lane. Rewriting a lane overwrites its data; the mask is unchanged.
  - Different line with a non-zero mask: the old fill completes. The new word starts a fresh fill in the same cycle.
- Fill completion:
  - Triggers: lane 3 written, line change, or DRAIN entry with a non-zero mask.
  - If out is free, the fill moves to out on the next edge; the fill is cleared, or reloaded with the new word on a line change.
  - If out is busy, the fill is marked full and held.
- Out buffer:
  - ddr_addr = BASE_ADDR + {line,3'b000}.
  - ddr_wr = out.valid.
  - The write is accepted on an edge where ddr_wr=1 and ddr_waitReq=0; out.valid clears that edge.
  - A waiting full fill moves in on the following edge, so there is one dead cycle between back-to-back writes.
  - The mask is written verbatim, so partial beats keep zeros in unwritten lanes.
- dl_wait (registered) = out.valid | fill full. It rises the cycle after the causing event.
  - The upstream must not assert dl_wr while dl_wait=1.
  - A violating word that still fits (same line, fill not full) is accepted.
  - Otherwise the word is dropped and overflow is set. overflow clears only on reset.
- Simultaneous events:
  - dl_wr on the same cycle as dl_cs falling: the word is accepted first, then the drain starts.
  - Out accepted on the same edge a fill completes: the fill moves in on that edge.
- dl_wr in IDLE or DRAIN is ignored and does not set overflow.
- Throughput: 1 word/cycle into fill. Latency from lane-3 write to ddr_wr=1 is 1 cycle.

Decomposition:
- Shared package cave_dl_pkg:
  - LANES=4, BEAT_BYTES=8, DDR_ADDR_W=32.
  - state_t enum {IDLE, ACTIVE, DRAIN}.
  - beat_t struct {data[63:0], mask[7:0], line}.
- One sub-module: dl_beat_buffer.
  - Holds the out-register handshake: load, valid, accept on !waitReq.
  - Reused as a single-entry Avalon write holder.

Test Plan:
- Words 0x1111,0x2222,0x3333,0x4444 at addr 0,2,4,6 → one write: addr=BASE, din=0x4444_3333_2222_1111, mask=0xFF; done pulses after dl_cs falls.
- Words at addr 8 and 10, then dl_cs falls → write addr=BASE+8, din=0x0000_0000_BBBB_AAAA, mask=0x0F; done one cycle after the write is accepted.
- Word at addr 0 then addr 0x20 → write addr BASE+0 mask=0x03, then at end write addr BASE+0x20 mask=0x03.
- ddr_waitReq held high 10 cycles during the first beat while the second beat fills → ddr_wr, addr and din stable all 10 cycles; dl_wait=1 once the fill is full; the second write follows 2 cycles after the first is accepted.
- dl_wr on a new line while dl_wait=1 and the fill is full → word dropped, overflow=1 until reset_n pulse.
- reset_n low while ddr_wr=1 with waitReq=1 → ddr_wr=0 and dl_wait=0 asynchronously; no write after release until a new dl_cs rise.
